mc_ctrl: RTL
============

Name: mc_ctrl

Overview:
- Multi-cycle control sequencer for the 16-bit MIPS16e-style core.
- Takes the 6-bit op_type class from the instruction recoder and walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Arbitrates the single memory port between instruction fetch and load/store.
- Drives PC, IR and register-file write enables, and handles the interrupt/trap entry.

Parameters:
- OPT_W, 6, width of the op_type class input.
- MAX_WAIT, 15, memory wait cycles tolerated before a bus-error trap; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- op_type  in  6  class code from the recoder; valid in DECODE onward
- branch_taken  in  1  datapath condition (T==0 / reg==0 result); valid in EXEC
- irq  in  1  level interrupt request
- int_en  in  1  global interrupt enable from IH register bit
- mem_ack  in  1  memory ready/done for the current request
- mem_req  out  1  memory access request
- mem_we  out  1  1 = store
- mem_sel  out  1  address source: 0 = PC, 1 = ALU result
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC
- pc_src  out  2  0 = PC+1, 1 = branch target, 2 = register (JR/JALR), 3 = vector
- alu_en  out  1  ALU result register capture
- rf_we  out  1  register-file write
- rf_wsel  out  2  0 = ALU, 1 = mem data, 2 = PC (link), 3 = special (SP/IH/T)
- trap_cause  out  2  0 = irq, 1 = INT instr, 2 = illegal, 3 = bus timeout; valid with pc_src=3
- state_o  out  3  current state, for debug
- busy  out  1  high in every state except FETCH while waiting for mem_ack

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Reset (async, rst_n low):
  - state = FETCH; wait counter = 0.
  - All outputs 0 except state_o = 0. mem_req is asserted only after reset is released.
- Outputs are Moore-decoded from the state, except pc_we/ir_we/rf_we, which are gated by the transition condition of the same cycle.
- FETCH:
  - mem_req=1, mem_sel=0, mem_we=0.
  - On mem_ack: ir_we=1, pc_we=1, pc_src=0, go to DECODE.
  - Otherwise stay and increment the wait counter.
  - Counter reaching MAX_WAIT (MAX_WAIT>0) goes to TRAP with cause 3.
- DECODE: one cycle, always goes to EXEC.
  - op_type NOP (0) goes to FETCH instead.
  - Any op_type not in the package class list goes to TRAP with cause 2.
  - op_type INT (11) goes to TRAP with cause 1.
- EXEC: alu_en=1, then by class:
  - ALU/ALUI/CMP/MT: go to WB.
  - LW/SW: go to MEM.
  - B: pc_we=1, pc_src=1, go to FETCH.
  - BC: pc_we=branch_taken, pc_src=1, go to FETCH.
  - JR: pc_we=1, pc_src=2, go to FETCH.
  - JALR: pc_we=1, pc_src=2, rf_we=1, rf_wsel=2, go to FETCH.
- MEM:
  - mem_req=1, mem_sel=1, mem_we=(class==SW).
  - Wait for mem_ack with the same timeout rule as FETCH.
  - On ack: LW goes to WB; SW goes to FETCH.
- WB: rf_we=1; rf_wsel by class: ALU/ALUI = 0, LW = 1, CMP/MT = 3. Next state is FETCH.
- Interrupt check, on any transition into FETCH: if irq && int_en, go to TRAP with cause 0 instead.
- TRAP: one cycle; pc_we=1, pc_src=3, rf_we=1, rf_wsel=3 (save return PC to EPC slot), then FETCH.
- Memory arbitration: mem_req is never high in DECODE/EXEC/WB/TRAP, so fetch and data access are never concurrent.
- mem_ack outside FETCH/MEM is ignored. The wait counter clears on each state entry.
- Latency with zero-wait memory (ack in the first request cycle):
  - ALU: 4 cycles; LW: 5; SW: 4; branch/jump: 3; NOP: 2.
- Reset mid-access drops mem_req asynchronously; there is no partial writeback.

Decomposition:
- Package mc_pkg:
  - State encodings.
  - op_type class constants: NOP=0, ALU=1, ALUI=2, LW=3, SW=4, B=5, BC=6, JR=7, JALR=8, CMP=9, MT=10, INT=11.
  - pc_src/rf_wsel/trap_cause encodings.
- Sub-module mc_wait_timer: the wait counter with clear/enable and timeout output.

Test Plan:
- ALU op (op_type=1), ack in the first cycle → states 0,1,2,4,0.
  - ir_we and pc_we high in cycle 0; rf_we=1 with rf_wsel=0 in cycle 3.
- LW (3) with 2 wait cycles in MEM → mem_req held with mem_sel=1, mem_we=0 for 3 cycles, then WB with rf_wsel=1.
  - Total 7 cycles.
- BC (6) with branch_taken=0, then with branch_taken=1 → pc_we=0, then pc_we=1 with pc_src=1, in the EXEC cycle; both go directly to FETCH.
- irq=1, int_en=1 asserted during WB → next state TRAP (5) with trap_cause=0 and pc_src=3, then FETCH.
  - With int_en=0 there is no trap.
- Memory never acks in FETCH (MAX_WAIT=15) → TRAP with cause 3 after 15 wait cycles.
  - op_type=63 → TRAP with cause 2 directly from DECODE.
- rst_n pulsed low mid-MEM → outputs 0 immediately; after release, FETCH with mem_req=1 next cycle.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the mc_ctrl multi-cycle sequencer: states, op_type classes,
// mux selects, trap causes and the decoded control word.
package mc_pkg;

    localparam int unsigned OPT_W_DEF = 6;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    // op_type classes produced by the instruction recoder
    localparam int unsigned OP_NOP  = 0;
    localparam int unsigned OP_ALU  = 1;
    localparam int unsigned OP_ALUI = 2;
    localparam int unsigned OP_LW   = 3;
    localparam int unsigned OP_SW   = 4;
    localparam int unsigned OP_B    = 5;
    localparam int unsigned OP_BC   = 6;
    localparam int unsigned OP_JR   = 7;
    localparam int unsigned OP_JALR = 8;
    localparam int unsigned OP_CMP  = 9;
    localparam int unsigned OP_MT   = 10;
    localparam int unsigned OP_INT  = 11;

    localparam logic [1:0] PC_INC = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_REG = 2'd2;
    localparam logic [1:0] PC_VEC = 2'd3;

    localparam logic [1:0] WS_ALU  = 2'd0;
    localparam logic [1:0] WS_MEM  = 2'd1;
    localparam logic [1:0] WS_LINK = 2'd2;
    localparam logic [1:0] WS_SPEC = 2'd3;

    localparam logic [1:0] TC_IRQ = 2'd0;
    localparam logic [1:0] TC_INT = 2'd1;
    localparam logic [1:0] TC_ILL = 2'd2;
    localparam logic [1:0] TC_BUS = 2'd3;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_sel;
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       alu_en;
        logic       rf_we;
        logic [1:0] rf_wsel;
        logic [1:0] trap_cause;
        logic       busy;
    } ctrl_t;

    // Register-file write source for classes that finish in WB
    function automatic logic [1:0] wb_src(input int unsigned opc);
        logic [1:0] sel;
        sel = WS_ALU;
        if (opc == OP_LW) begin
            sel = WS_MEM;
        end else if (opc == OP_CMP || opc == OP_MT) begin
            sel = WS_SPEC;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-cycle counter: counts stalled request cycles and flags the cycle
// in which the MAX_WAIT-th consecutive stall occurs (MAX_WAIT = 0 never times out).
module mc_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic timeout_c
);

    localparam int unsigned     CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_c = (MAX_WAIT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB,
// owns the single memory port and handles interrupt/trap entry.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned OPT_W    = OPT_W_DEF,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OPT_W-1:0] op_type,
    input  logic             branch_taken,
    input  logic             irq,
    input  logic             int_en,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             alu_en,
    output logic             rf_we,
    output logic [1:0]       rf_wsel,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state_o,
    output logic             busy
);

    state_e           state_q;
    state_e           state_d;
    logic [OPT_W-1:0] opc_q;
    logic [OPT_W-1:0] opc_d;
    logic [1:0]       cause_q;
    logic [1:0]       cause_d;
    ctrl_t            ctrl_c;
    ctrl_t            ctrl;
    logic             wait_en;
    logic             wait_clr;
    logic             timeout_c;

    mc_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (wait_clr),
        .en_i      (wait_en),
        .timeout_c (timeout_c)
    );

    // Next state and Moore control decode; write strobes follow the same-cycle transition
    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        cause_d     = cause_q;
        ctrl_c      = '0;
        ctrl_c.busy = 1'b1;
        wait_en     = 1'b0;

        case (state_q)
            ST_FETCH: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.busy    = mem_ack;
                wait_en        = ~mem_ack;
                if (mem_ack) begin
                    ctrl_c.ir_we  = 1'b1;
                    ctrl_c.pc_we  = 1'b1;
                    ctrl_c.pc_src = PC_INC;
                    state_d       = ST_DECODE;
                end else if (timeout_c) begin
                    cause_d = TC_BUS;
                    state_d = ST_TRAP;
                end
            end

            ST_DECODE: begin
                opc_d = op_type;
                if (op_type == OPT_W'(OP_NOP)) begin
                    state_d = ST_FETCH;
                end else if (op_type == OPT_W'(OP_INT)) begin
                    cause_d = TC_INT;
                    state_d = ST_TRAP;
                end else if (op_type > OPT_W'(OP_INT)) begin
                    cause_d = TC_ILL;
                    state_d = ST_TRAP;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                ctrl_c.alu_en = 1'b1;
                state_d       = ST_FETCH;
                case (opc_q)
                    OPT_W'(OP_ALU), OPT_W'(OP_ALUI),
                    OPT_W'(OP_CMP), OPT_W'(OP_MT): begin
                        state_d = ST_WB;
                    end
                    OPT_W'(OP_LW), OPT_W'(OP_SW): begin
                        state_d = ST_MEM;
                    end
                    OPT_W'(OP_B): begin
                        ctrl_c.pc_we  = 1'b1;
                        ctrl_c.pc_src = PC_BR;
                    end
                    OPT_W'(OP_BC): begin
                        ctrl_c.pc_we  = branch_taken;
                        ctrl_c.pc_src = PC_BR;
                    end
                    OPT_W'(OP_JR): begin
                        ctrl_c.pc_we  = 1'b1;
                        ctrl_c.pc_src = PC_REG;
                    end
                    OPT_W'(OP_JALR): begin
                        ctrl_c.pc_we   = 1'b1;
                        ctrl_c.pc_src  = PC_REG;
                        ctrl_c.rf_we   = 1'b1;
                        ctrl_c.rf_wsel = WS_LINK;
                    end
                    default: begin
                        state_d = ST_FETCH;
                    end
                endcase
            end

            ST_MEM: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.mem_sel = 1'b1;
                ctrl_c.mem_we  = (opc_q == OPT_W'(OP_SW));
                wait_en        = ~mem_ack;
                if (mem_ack) begin
                    state_d = (opc_q == OPT_W'(OP_LW)) ? ST_WB : ST_FETCH;
                end else if (timeout_c) begin
                    cause_d = TC_BUS;
                    state_d = ST_TRAP;
                end
            end

            ST_WB: begin
                ctrl_c.rf_we   = 1'b1;
                ctrl_c.rf_wsel = wb_src(32'(opc_q));
                state_d        = ST_FETCH;
            end

            ST_TRAP: begin
                ctrl_c.pc_we      = 1'b1;
                ctrl_c.pc_src     = PC_VEC;
                ctrl_c.rf_we      = 1'b1;
                ctrl_c.rf_wsel    = WS_SPEC;
                ctrl_c.trap_cause = cause_q;
                state_d           = ST_FETCH;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        // Pending interrupt diverts an instruction's return to FETCH; the handler's
        // own first fetch (leaving TRAP) is never preempted.
        if (state_d == ST_FETCH && state_q != ST_FETCH && state_q != ST_TRAP &&
            irq && int_en) begin
            cause_d = TC_IRQ;
            state_d = ST_TRAP;
        end
    end

    assign wait_clr = (state_d != state_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            opc_q   <= '0;
            cause_q <= TC_IRQ;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            cause_q <= cause_d;
        end
    end

    // Reset forces every control output low at once, including an in-flight mem_req
    assign ctrl = rst_n ? ctrl_c : '0;

    assign mem_req    = ctrl.mem_req;
    assign mem_we     = ctrl.mem_we;
    assign mem_sel    = ctrl.mem_sel;
    assign ir_we      = ctrl.ir_we;
    assign pc_we      = ctrl.pc_we;
    assign pc_src     = ctrl.pc_src;
    assign alu_en     = ctrl.alu_en;
    assign rf_we      = ctrl.rf_we;
    assign rf_wsel    = ctrl.rf_wsel;
    assign trap_cause = ctrl.trap_cause;
    assign busy       = ctrl.busy;
    assign state_o    = state_q;

endmodule
